// File: rtl/drone_pkg.sv
// Shared definitions for the drone game: state codes, map end position and
// the Moore output decode used by the control unit.
package drone_pkg;

  typedef enum logic [3:0] {
    INICIAL  = 4'h0,
    PREPARA  = 4'h1,
    MODO     = 4'h2,
    VIDA     = 4'h3,
    MAPA     = 4'h4,
    ESPERA   = 4'h5,
    LE_MAPA  = 4'h6,
    CHECA    = 4'h7,
    CONTA    = 4'h8,
    VERIFICA = 4'h9,
    PROXIMA  = 4'hA,
    GANHOU   = 4'hB,
    PERDEU   = 4'hC
  } estado_t;

  localparam logic [3:0] MAPA_FIM = 4'hF;

  typedef struct packed {
    logic zeraPosicoes;
    logic resetaVidas;
    logic zeraT;
    logic contaT;
    logic desloca;
    logic escolhe_modo;
    logic escolhe_vida;
    logic escolhe_mapa;
    logic checa_colisao;
    logic atualiza;
    logic pronto;
    logic ganhou;
    logic perdeu;
  } saidas_t;

  function automatic saidas_t decodifica(estado_t e);
    saidas_t s;
    s = '0;
    case (e)
      PREPARA: begin
        s.zeraPosicoes = 1'b1;
        s.resetaVidas  = 1'b1;
        s.zeraT        = 1'b1;
      end
      MODO:   s.escolhe_modo = 1'b1;
      VIDA:   s.escolhe_vida = 1'b1;
      MAPA:   s.escolhe_mapa = 1'b1;
      ESPERA: begin
        s.contaT  = 1'b1;
        s.desloca = 1'b1;
      end
      CHECA: begin
        s.atualiza      = 1'b1;
        s.checa_colisao = 1'b1;
      end
      CONTA:   s.checa_colisao = 1'b1;
      PROXIMA: s.zeraT = 1'b1;
      GANHOU: begin
        s.pronto = 1'b1;
        s.ganhou = 1'b1;
      end
      PERDEU: begin
        s.pronto = 1'b1;
        s.perdeu = 1'b1;
      end
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/edge_detector.sv
// Rising-edge pulse generator: one register stage, pulse lasts one cycle
// however long the level stays high.
module edge_detector (
  input  logic clock,
  input  logic reset,
  input  logic sinal,
  output logic pulso
);

  logic anterior;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) anterior <= 1'b0;
    else        anterior <= sinal;
  end

  assign pulso = sinal & ~anterior;

endmodule

// File: rtl/unidade_controle_drone.sv
// Moore control unit for the drone game. Optional macro DRONE_TIMEOUT_EN makes
// a move-timer expiry in ESPERA lose the game; otherwise timeout is ignored.
module unidade_controle_drone
  import drone_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       confirma,
  input  logic       borda_movimento,
  input  logic       colisao,
  input  logic       timeout,
  input  logic       fim_mapa,
  output logic       zeraPosicoes,
  output logic       resetaVidas,
  output logic       zeraT,
  output logic       contaT,
  output logic       desloca,
  output logic       escolhe_modo,
  output logic       escolhe_vida,
  output logic       escolhe_mapa,
  output logic       checa_colisao,
  output logic       atualiza,
  output logic       pronto,
  output logic       ganhou,
  output logic       perdeu,
  output logic [3:0] db_estado
);

  estado_t estado, prox;
  saidas_t saidas;
  logic    iniciar_pulso, confirma_pulso;

  edge_detector u_ed_iniciar (
    .clock (clock), .reset (reset), .sinal (iniciar),  .pulso (iniciar_pulso)
  );
  edge_detector u_ed_confirma (
    .clock (clock), .reset (reset), .sinal (confirma), .pulso (confirma_pulso)
  );

`ifndef DRONE_TIMEOUT_EN
  logic unused_timeout;
  assign unused_timeout = timeout;
`endif

  always_comb begin
    prox = estado;
    case (estado)
      INICIAL:  if (iniciar_pulso) prox = PREPARA;
      PREPARA:  prox = MODO;
      MODO:     if (confirma_pulso) prox = VIDA;
      VIDA:     if (confirma_pulso) prox = MAPA;
      MAPA:     if (confirma_pulso) prox = ESPERA;
      ESPERA: begin
        // A move in the same cycle as a timer expiry is still honoured.
        if (borda_movimento) prox = LE_MAPA;
`ifdef DRONE_TIMEOUT_EN
        else if (timeout)    prox = PERDEU;
`endif
      end
      LE_MAPA:  prox = CHECA;
      CHECA:    prox = CONTA;
      CONTA:    prox = VERIFICA;
      VERIFICA: begin
        if (colisao)       prox = PERDEU;
        else if (fim_mapa) prox = GANHOU;
        else               prox = PROXIMA;
      end
      PROXIMA:  prox = ESPERA;
      GANHOU, PERDEU: if (iniciar_pulso) prox = PREPARA;
      default:  prox = INICIAL;
    endcase
  end

  // Outputs are registered from the next state so they line up with estado.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado <= INICIAL;
      saidas <= '0;
    end else begin
      estado <= prox;
      saidas <= decodifica(prox);
    end
  end

  assign zeraPosicoes  = saidas.zeraPosicoes;
  assign resetaVidas   = saidas.resetaVidas;
  assign zeraT         = saidas.zeraT;
  assign contaT        = saidas.contaT;
  assign desloca       = saidas.desloca;
  assign escolhe_modo  = saidas.escolhe_modo;
  assign escolhe_vida  = saidas.escolhe_vida;
  assign escolhe_mapa  = saidas.escolhe_mapa;
  assign checa_colisao = saidas.checa_colisao;
  assign atualiza      = saidas.atualiza;
  assign pronto        = saidas.pronto;
  assign ganhou        = saidas.ganhou;
  assign perdeu        = saidas.perdeu;
  assign db_estado     = estado;

endmodule

// File: tb/tb_unidade_controle_drone.sv
// Directed bench for unidade_controle_drone: table of per-cycle vectors plus
// hand sequences for timeout handling and asynchronous reset mid-game.
module tb_unidade_controle_drone;

  // Input bundle {iniciar, confirma, borda_movimento, colisao, timeout, fim_mapa}
  localparam logic [5:0] N_ = 6'b000000;
  localparam logic [5:0] I_ = 6'b100000;
  localparam logic [5:0] C_ = 6'b010000;
  localparam logic [5:0] B_ = 6'b001000;
  localparam logic [5:0] L_ = 6'b000100;
  localparam logic [5:0] T_ = 6'b000010;
  localparam logic [5:0] F_ = 6'b000001;

  // Output order: zeraPosicoes resetaVidas zeraT contaT desloca escolhe_modo
  // escolhe_vida escolhe_mapa checa_colisao atualiza pronto ganhou perdeu
  function automatic logic [12:0] outs_of(logic [3:0] est);
    case (est)
      4'h1:    return 13'b1110000000000;
      4'h2:    return 13'b0000010000000;
      4'h3:    return 13'b0000001000000;
      4'h4:    return 13'b0000000100000;
      4'h5:    return 13'b0001100000000;
      4'h7:    return 13'b0000000011000;
      4'h8:    return 13'b0000000010000;
      4'hA:    return 13'b0010000000000;
      4'hB:    return 13'b0000000000110;
      4'hC:    return 13'b0000000000101;
      default: return 13'b0000000000000;
    endcase
  endfunction

  typedef struct {
    logic [5:0] in;
    logic [3:0] est;
    string      nome;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic iniciar = 0, confirma = 0, borda_movimento = 0;
  logic colisao = 0, timeout = 0, fim_mapa = 0;
  logic zeraPosicoes, resetaVidas, zeraT, contaT, desloca;
  logic escolhe_modo, escolhe_vida, escolhe_mapa, checa_colisao, atualiza;
  logic pronto, ganhou, perdeu;
  logic [3:0] db_estado;
  logic [16:0] got;

  int n_checks = 0;
  int n_errors = 0;
  logic [16:0] exp_q[$];
  vec_t tab[$];

  unidade_controle_drone dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .confirma(confirma),
    .borda_movimento(borda_movimento), .colisao(colisao), .timeout(timeout),
    .fim_mapa(fim_mapa), .zeraPosicoes(zeraPosicoes), .resetaVidas(resetaVidas),
    .zeraT(zeraT), .contaT(contaT), .desloca(desloca), .escolhe_modo(escolhe_modo),
    .escolhe_vida(escolhe_vida), .escolhe_mapa(escolhe_mapa),
    .checa_colisao(checa_colisao), .atualiza(atualiza), .pronto(pronto),
    .ganhou(ganhou), .perdeu(perdeu), .db_estado(db_estado)
  );

  // Clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: run still active at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  assign got = {db_estado, zeraPosicoes, resetaVidas, zeraT, contaT, desloca,
                escolhe_modo, escolhe_vida, escolhe_mapa, checa_colisao,
                atualiza, pronto, ganhou, perdeu};

  // Driver tasks
  task automatic drive(input logic [5:0] in);
    {iniciar, confirma, borda_movimento, colisao, timeout, fim_mapa} = in;
  endtask

  task automatic check(input string nome, input logic [16:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got state=%h outs=%b, required state=%h outs=%b",
               nome, got[16:13], got[12:0], exp[16:13], exp[12:0]);
    end
  endtask

  task automatic step(input logic [5:0] in, input logic [3:0] est, input string nome);
    drive(in);
    @(posedge clock);
    @(negedge clock);
    check(nome, {est, outs_of(est)});
  endtask

  task automatic menu_to_espera();
    step(C_, 4'h3, "menu_vida");
    step(N_, 4'h3, "menu_vida_hold");
    step(C_, 4'h4, "menu_mapa");
    step(N_, 4'h4, "menu_mapa_hold");
    step(C_, 4'h5, "menu_espera");
    step(N_, 4'h5, "menu_espera_hold");
  endtask

  initial begin
    // Main vector table, one row per clock
    tab.push_back('{I_, 4'h1, "ini_prepara"});
    tab.push_back('{I_, 4'h2, "prepara_one_cycle"});
    tab.push_back('{N_, 4'h2, "modo_hold"});
    tab.push_back('{C_, 4'h3, "conf1_vida"});
    for (int k = 0; k < 4; k++) tab.push_back('{C_, 4'h3, "conf1_held"});
    tab.push_back('{N_, 4'h3, "conf1_release"});
    tab.push_back('{C_, 4'h4, "conf2_mapa"});
    for (int k = 0; k < 4; k++) tab.push_back('{C_, 4'h4, "conf2_held"});
    tab.push_back('{N_, 4'h4, "conf2_release"});
    tab.push_back('{C_, 4'h5, "conf3_espera"});
    for (int k = 0; k < 4; k++) tab.push_back('{C_, 4'h5, "conf3_held"});
    tab.push_back('{N_, 4'h5, "conf3_release"});
    tab.push_back('{B_, 4'h6, "move_le_mapa"});
    tab.push_back('{N_, 4'h7, "move_checa"});
    tab.push_back('{N_, 4'h8, "move_conta"});
    tab.push_back('{N_, 4'h9, "move_verifica"});
    tab.push_back('{N_, 4'hA, "move_proxima"});
    tab.push_back('{N_, 4'h5, "move_back_espera"});
    tab.push_back('{I_, 4'h5, "ini_ignored_espera"});
    tab.push_back('{C_, 4'h5, "conf_ignored_espera"});
    tab.push_back('{B_ | T_, 4'h6, "move_beats_timeout"});
    tab.push_back('{N_, 4'h7, "m2_checa"});
    tab.push_back('{N_, 4'h8, "m2_conta"});
    tab.push_back('{N_, 4'h9, "m2_verifica"});
    tab.push_back('{L_ | F_, 4'hC, "col_and_fim_perdeu"});
    tab.push_back('{N_, 4'hC, "perdeu_hold"});
    tab.push_back('{C_, 4'hC, "conf_ignored_perdeu"});
    tab.push_back('{I_, 4'h1, "restart_from_perdeu"});
    tab.push_back('{N_, 4'h2, "restart_modo"});
    tab.push_back('{C_, 4'h3, "g_vida"});
    tab.push_back('{N_, 4'h3, "g_vida_hold"});
    tab.push_back('{C_, 4'h4, "g_mapa"});
    tab.push_back('{N_, 4'h4, "g_mapa_hold"});
    tab.push_back('{C_, 4'h5, "g_espera"});
    tab.push_back('{N_, 4'h5, "g_espera_hold"});
    tab.push_back('{B_, 4'h6, "g_le_mapa"});
    tab.push_back('{N_, 4'h7, "g_checa"});
    tab.push_back('{N_, 4'h8, "g_conta"});
    tab.push_back('{N_, 4'h9, "g_verifica"});
    tab.push_back('{F_, 4'hB, "fim_ganhou"});
    tab.push_back('{N_, 4'hB, "ganhou_hold"});
    tab.push_back('{I_, 4'h1, "restart_from_ganhou"});
    tab.push_back('{N_, 4'h2, "restart2_modo"});
    tab.push_back('{C_, 4'h3, "c_vida"});
    tab.push_back('{N_, 4'h3, "c_vida_hold"});
    tab.push_back('{C_, 4'h4, "c_mapa"});
    tab.push_back('{N_, 4'h4, "c_mapa_hold"});
    tab.push_back('{C_, 4'h5, "c_espera"});
    tab.push_back('{N_, 4'h5, "c_espera_hold"});
    tab.push_back('{B_, 4'h6, "c_le_mapa"});
    tab.push_back('{N_, 4'h7, "c_checa"});
    tab.push_back('{N_, 4'h8, "c_conta"});
    tab.push_back('{N_, 4'h9, "c_verifica"});
    tab.push_back('{L_, 4'hC, "col_perdeu"});
    tab.push_back('{I_, 4'h1, "restart3"});
    tab.push_back('{N_, 4'h2, "restart3_modo"});

    // Reset block: held low 3 cycles
    reset = 1'b0;
    drive(N_);
    repeat (3) @(negedge clock);
    check("in_reset", 17'h0);
    reset = 1'b1;
    @(negedge clock);
    check("after_reset", 17'h0);

    foreach (tab[i]) step(tab[i].in, tab[i].est, tab[i].nome);

    // Timeout behaviour in ESPERA
    menu_to_espera();
`ifdef DRONE_TIMEOUT_EN
    step(T_, 4'hC, "timeout_perdeu");
    step(N_, 4'hC, "timeout_perdeu_hold");
    step(I_, 4'h1, "timeout_restart");
    step(N_, 4'h2, "timeout_restart_modo");
    menu_to_espera();
`else
    step(T_, 4'h5, "timeout_ignored_1");
    step(T_, 4'h5, "timeout_ignored_2");
    step(N_, 4'h5, "timeout_ignored_3");
`endif

    // Move into CONTA via the expected queue, then reset asynchronously
    exp_q.push_back({4'h6, outs_of(4'h6)});
    exp_q.push_back({4'h7, outs_of(4'h7)});
    exp_q.push_back({4'h8, outs_of(4'h8)});
    drive(B_);
    while (exp_q.size() > 0) begin
      @(posedge clock);
      @(negedge clock);
      drive(N_);
      check("to_conta", exp_q.pop_front());
    end
    #1 reset = 1'b0;
    #1 check("async_reset_mid_conta", 17'h0);
    @(negedge clock);
    @(negedge clock);
    check("reset_held", 17'h0);
    reset = 1'b1;
    step(N_, 4'h0, "post_reset_idle");
    step(I_, 4'h1, "post_reset_prepara");
    step(N_, 4'h2, "post_reset_modo");

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
